// File: rtl/bus_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one unified bus.
// Data wins by default; a bounded data streak guarantees fetch progress.
package bus_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [63:0] data;
    logic [7:0]  strobe;
  } dbus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter logic [2:0]  ISIZE       = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  ibus_req_t   ireq,
  output ibus_resp_t  iresp,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic        creq_valid,
  output logic [63:0] creq_addr,
  output logic [2:0]  creq_size,
  output logic [63:0] creq_data,
  output logic [7:0]  creq_strobe,
  input  logic        cresp_ok,
  input  logic [63:0] cresp_data
);

  typedef enum logic [2:0] {
    IDLE,
    IBUSY,
    DBUSY,
    IRESP,
    DRESP
  } state_t;

  localparam logic [2:0] DSTREAK_MAX = 3'(MAX_DSTREAK);

  state_t      state_q, state_d;
  logic [2:0]  dstreak;
  logic [63:0] lat_addr;
  logic [2:0]  lat_size;
  logic [63:0] lat_data;
  logic [7:0]  lat_strobe;
  logic [63:0] rdata;
  logic        igrant, dgrant;
  logic        streak_full;
  logic        busy;

  assign streak_full = (dstreak >= DSTREAK_MAX);
  assign busy        = (state_q == IBUSY) || (state_q == DBUSY);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    igrant  = 1'b0;
    dgrant  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ireq.valid && (!dreq.valid || streak_full)) begin
          igrant  = 1'b1;
          state_d = IBUSY;
        end else if (dreq.valid) begin
          dgrant  = 1'b1;
          state_d = DBUSY;
        end
      end
      IBUSY:   if (cresp_ok) state_d = IRESP;
      DBUSY:   if (cresp_ok) state_d = DRESP;
      IRESP,
      DRESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      dstreak    <= '0;
      lat_addr   <= '0;
      lat_size   <= '0;
      lat_data   <= '0;
      lat_strobe <= '0;
      rdata      <= '0;
    end else begin
      state_q <= state_d;
      if (igrant) begin
        lat_addr   <= ireq.addr;
        lat_size   <= ISIZE;
        lat_data   <= '0;
        lat_strobe <= '0;
        dstreak    <= '0;
      end else if (dgrant) begin
        lat_addr   <= dreq.addr;
        lat_size   <= dreq.size;
        lat_data   <= dreq.data;
        lat_strobe <= dreq.strobe;
        // Only streaks that actually starve a pending fetch count.
        if (ireq.valid && !streak_full) dstreak <= dstreak + 3'd1;
      end
      if (busy && cresp_ok) rdata <= cresp_data;
    end
  end

  always_comb begin
    creq_valid  = busy;
    creq_addr   = busy ? lat_addr   : '0;
    creq_size   = busy ? lat_size   : '0;
    creq_data   = busy ? lat_data   : '0;
    creq_strobe = busy ? lat_strobe : '0;
  end

  always_comb begin
    iresp = '0;
    dresp = '0;
    if (state_q == IRESP) begin
      iresp.data_ok = 1'b1;
      iresp.data    = lat_addr[2] ? rdata[63:32] : rdata[31:0];
    end
    if (state_q == DRESP) begin
      dresp.data_ok = 1'b1;
      dresp.data    = rdata;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table for single transactions,
// hand-written sequences for fairness, stall and mid-transaction reset.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;
  logic        creq_valid;
  logic [63:0] creq_addr;
  logic [2:0]  creq_size;
  logic [63:0] creq_data;
  logic [7:0]  creq_strobe;
  logic        cresp_ok;
  logic [63:0] cresp_data;

  int checks   = 0;
  int failures = 0;

  bus_arbiter #(.MAX_DSTREAK(4), .ISIZE(3'b010)) dut (
    .clk         (clk),
    .reset       (reset),
    .ireq        (ireq),
    .iresp       (iresp),
    .dreq        (dreq),
    .dresp       (dresp),
    .creq_valid  (creq_valid),
    .creq_addr   (creq_addr),
    .creq_size   (creq_size),
    .creq_data   (creq_data),
    .creq_strobe (creq_strobe),
    .cresp_ok    (cresp_ok),
    .cresp_data  (cresp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Both responses must never pulse together.
  always @(negedge clk) begin
    if (reset === 1'b1) check("exclusive_data_ok", 64'(iresp.data_ok & dresp.data_ok), 64'd0);
  end

  typedef struct {
    logic        iv;
    logic [63:0] ia;
    logic        dv;
    logic [63:0] da;
    logic [2:0]  dsz;
    logic [63:0] dd;
    logic [7:0]  ds;
    logic        ok;
    logic [63:0] cd;
    logic        e_cv;
    logic [63:0] e_ca;
    logic [2:0]  e_csz;
    logic [63:0] e_cd;
    logic [7:0]  e_cs;
    logic        e_iok;
    logic [31:0] e_id;
    logic        e_dok;
    logic [63:0] e_dd;
  } vec_t;

  vec_t vecs[17];

  task automatic drive(input logic iv, input logic [63:0] ia, input logic dv, input logic [63:0] da,
                       input logic [2:0] dsz, input logic [63:0] dd, input logic [7:0] ds,
                       input logic ok, input logic [63:0] cd);
    ireq.valid  = iv;
    ireq.addr   = ia;
    dreq.valid  = dv;
    dreq.addr   = da;
    dreq.size   = dsz;
    dreq.data   = dd;
    dreq.strobe = ds;
    cresp_ok    = ok;
    cresp_data  = cd;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int grants;
    int cyc;
    logic is_i;

    // Rows: inputs for a cycle, then the outputs expected in that same cycle.
    vecs[0]  = '{0, 64'h0, 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 64'h0,
                 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 32'h0, 0, 64'h0};
    vecs[1]  = '{1, 64'h8000_0004, 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 64'h0,
                 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 32'h0, 0, 64'h0};
    vecs[2]  = '{1, 64'h8000_0004, 0, 64'h0, 3'd0, 64'h0, 8'h0, 1, 64'h1111_2222_3333_4444,
                 1, 64'h8000_0004, 3'b010, 64'h0, 8'h0, 0, 32'h0, 0, 64'h0};
    vecs[3]  = '{0, 64'h0, 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 64'h0,
                 0, 64'h0, 3'd0, 64'h0, 8'h0, 1, 32'h1111_2222, 0, 64'h0};
    vecs[4]  = '{0, 64'h0, 0, 64'h0, 3'd0, 64'h0, 8'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF,
                 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 32'h0, 0, 64'h0};
    vecs[5]  = '{0, 64'h0, 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 64'h0,
                 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 32'h0, 0, 64'h0};
    vecs[6]  = '{1, 64'h1000, 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 64'h0,
                 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 32'h0, 0, 64'h0};
    vecs[7]  = '{0, 64'h0, 0, 64'h0, 3'd0, 64'h0, 8'h0, 1, 64'hAAAA_BBBB_CCCC_DDDD,
                 1, 64'h1000, 3'b010, 64'h0, 8'h0, 0, 32'h0, 0, 64'h0};
    vecs[8]  = '{0, 64'h0, 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 64'h0,
                 0, 64'h0, 3'd0, 64'h0, 8'h0, 1, 32'hCCCC_DDDD, 0, 64'h0};
    vecs[9]  = '{0, 64'h0, 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 64'h0,
                 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 32'h0, 0, 64'h0};
    vecs[10] = '{1, 64'h8000_0000, 1, 64'h8010_0000, 3'b011, 64'hDEAD_BEEF, 8'hFF, 0, 64'h0,
                 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 32'h0, 0, 64'h0};
    vecs[11] = '{1, 64'h8000_0000, 1, 64'h8010_0000, 3'b011, 64'hDEAD_BEEF, 8'hFF, 1, 64'h0123_4567_89AB_CDEF,
                 1, 64'h8010_0000, 3'b011, 64'hDEAD_BEEF, 8'hFF, 0, 32'h0, 0, 64'h0};
    vecs[12] = '{1, 64'h8000_0000, 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 64'h0,
                 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 32'h0, 1, 64'h0123_4567_89AB_CDEF};
    vecs[13] = '{1, 64'h8000_0000, 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 64'h0,
                 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 32'h0, 0, 64'h0};
    vecs[14] = '{0, 64'h0, 0, 64'h0, 3'd0, 64'h0, 8'h0, 1, 64'h5555_6666_7777_8888,
                 1, 64'h8000_0000, 3'b010, 64'h0, 8'h0, 0, 32'h0, 0, 64'h0};
    vecs[15] = '{0, 64'h0, 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 64'h0,
                 0, 64'h0, 3'd0, 64'h0, 8'h0, 1, 32'h7777_8888, 0, 64'h0};
    vecs[16] = '{0, 64'h0, 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 64'h0,
                 0, 64'h0, 3'd0, 64'h0, 8'h0, 0, 32'h0, 0, 64'h0};

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("reset creq_valid", 64'(creq_valid), 64'd0);
    check("reset creq_addr", creq_addr, 64'd0);
    check("reset iresp", 64'(iresp), 64'd0);
    check("reset dresp", 64'(dresp), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].da, vecs[i].dsz, vecs[i].dd,
            vecs[i].ds, vecs[i].ok, vecs[i].cd);
      check($sformatf("row%0d creq_valid", i), 64'(creq_valid), 64'(vecs[i].e_cv));
      check($sformatf("row%0d creq_addr", i), creq_addr, vecs[i].e_ca);
      check($sformatf("row%0d creq_size", i), 64'(creq_size), 64'(vecs[i].e_csz));
      check($sformatf("row%0d creq_data", i), creq_data, vecs[i].e_cd);
      check($sformatf("row%0d creq_strobe", i), 64'(creq_strobe), 64'(vecs[i].e_cs));
      check($sformatf("row%0d iresp_ok", i), 64'(iresp.data_ok), 64'(vecs[i].e_iok));
      check($sformatf("row%0d iresp_data", i), 64'(iresp.data), 64'(vecs[i].e_id));
      check($sformatf("row%0d dresp_ok", i), 64'(dresp.data_ok), 64'(vecs[i].e_dok));
      check($sformatf("row%0d dresp_data", i), dresp.data, vecs[i].e_dd);
      @(negedge clk);
    end

    // Fairness: both held, immediate completion; expect D D D D I repeating.
    grants = 0;
    cyc    = 0;
    drive(1, 64'h1000_0000, 1, 64'h0000_D000, 3'b011, 64'h77, 8'hFF, 0, 64'h0);
    while (grants < 25 && cyc < 200) begin
      cresp_ok = creq_valid;
      if (creq_valid) begin
        is_i = (creq_addr == 64'h1000_0000);
        check($sformatf("fair grant%0d is_ibus", grants), 64'(is_i), 64'((grants % 5) == 4));
        check("fair dstreak_bound", 64'(dut.dstreak <= 3'd4), 64'd1);
        grants++;
      end
      @(negedge clk);
      cyc++;
    end
    check("fair grant_count", 64'(grants), 64'd25);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("fair drained", 64'(creq_valid), 64'd0);

    // Downstream stall with the data address toggling upstream.
    drive(0, 0, 1, 64'h2000, 3'b011, 64'h55, 8'h0F, 0, 64'h0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      dreq.addr = dreq.addr ^ 64'hFFFF_0000;
      check($sformatf("stall%0d creq_valid", i), 64'(creq_valid), 64'd1);
      check($sformatf("stall%0d creq_addr", i), creq_addr, 64'h2000);
      check($sformatf("stall%0d creq_strobe", i), 64'(creq_strobe), 64'h0F);
      check($sformatf("stall%0d dresp_ok", i), 64'(dresp.data_ok), 64'd0);
      @(negedge clk);
    end
    dreq.valid = 1'b0;
    cresp_ok   = 1'b1;
    cresp_data = 64'h0000_0000_CAFE_F00D;
    @(negedge clk);
    cresp_ok = 1'b0;
    check("stall dresp_ok", 64'(dresp.data_ok), 64'd1);
    check("stall dresp_data", dresp.data, 64'h0000_0000_CAFE_F00D);
    @(negedge clk);
    check("stall single_pulse", 64'(dresp.data_ok), 64'd0);
    check("stall idle creq_valid", 64'(creq_valid), 64'd0);

    // Reset during DBUSY drops the transaction; a late completion is ignored.
    drive(0, 0, 1, 64'h3000, 3'b011, 64'h0, 8'h0, 0, 64'h0);
    @(negedge clk);
    check("rst busy creq_valid", 64'(creq_valid), 64'd1);
    dreq.valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst async creq_valid", 64'(creq_valid), 64'd0);
    check("rst async creq_addr", creq_addr, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cresp_ok   = 1'b1;
    cresp_data = 64'h1234;
    @(negedge clk);
    cresp_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst late%0d iresp_ok", i), 64'(iresp.data_ok), 64'd0);
      check($sformatf("rst late%0d dresp_ok", i), 64'(dresp.data_ok), 64'd0);
      check($sformatf("rst late%0d creq_valid", i), 64'(creq_valid), 64'd0);
      @(negedge clk);
    end
    // A fresh request granted on the next edge shows the FSM sits in IDLE.
    drive(0, 0, 1, 64'h4000, 3'b011, 64'h0, 8'h0, 0, 64'h0);
    @(negedge clk);
    check("rst idle regrant valid", 64'(creq_valid), 64'd1);
    check("rst idle regrant addr", creq_addr, 64'h4000);
    dreq.valid = 1'b0;
    cresp_ok   = 1'b1;
    cresp_data = 64'h9999;
    @(negedge clk);
    cresp_ok = 1'b0;
    check("rst idle regrant dresp_ok", 64'(dresp.data_ok), 64'd1);
    check("rst idle regrant dresp_data", dresp.data, 64'h9999);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
